// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch stage between the program counter and decode. Reads the
//   synchronous instruction ROM at the current PC, tags each returned word with
//   its address and buffers it in a small FIFO feeding decode over valid/ready.
//   The PC is only advanced (next_flag) when a fetch is actually issued or when
//   a jump redirect has to be loaded.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     defined   : a ROM response arriving while the queue is empty is presented
//                 to decode in its return cycle (issue->valid latency 1).
//     undefined : every word goes through the queue registers (latency 2).
//
//   Ports
//     clk         clock, all state on rising edge
//     reset       asynchronous active-low reset
//     prog_ctr    current PC value
//     next_flag   advance / load enable to the PC
//     flush       decode takes an absolute jump this cycle
//     halt_req    stop issuing new fetches
//     halted      stopped with nothing queued or in flight
//     imem_rd     ROM read strobe
//     imem_addr   ROM address (always equals prog_ctr)
//     imem_data   ROM data, valid the cycle after imem_rd
//     inst_valid  head entry valid
//     inst_ready  decode accepts head
//     inst_out    head instruction
//     inst_pc     address of head instruction
module fetch_queue #(
    parameter int D     = 12,
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] prog_ctr,
    output logic         next_flag,
    input  logic         flush,
    input  logic         halt_req,
    output logic         halted,
    output logic         imem_rd,
    output logic [D-1:0] imem_addr,
    input  logic [W-1:0] imem_data,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [W-1:0] inst_out,
    output logic [D-1:0] inst_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [D-1:0] pc;
        logic [W-1:0] inst;
    } entry_t;

    typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

    state_t                 state_q, state_d;
    entry_t [DEPTH-1:0]     mem_q;
    logic   [AW-1:0]        rptr_q, wptr_q;
    logic   [CW-1:0]        count_q;
    logic                   inflight_q;
    logic   [D-1:0]         tag_q;

    logic                   q_empty;
    logic                   byp;
    logic                   pop;
    logic                   q_pop;
    logic                   push;
    logic                   issue;
    logic   [CW:0]          occ;

    assign q_empty = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    // Response goes straight to decode only when nothing older is queued.
    assign byp = inflight_q & q_empty & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign inst_valid = ~q_empty | byp;
    assign pop        = inst_valid & inst_ready;
    // A pop under flush is not a queue pop: the whole queue is discarded anyway.
    assign q_pop      = pop & ~q_empty & ~flush;
    // A bypassed word that decode takes immediately never occupies an entry.
    assign push       = inflight_q & ~flush & ~(byp & inst_ready);

    // Occupancy a new issue would see once its data returns: the slot freed by
    // this cycle's pop is already usable, giving one fetch per cycle.
    assign occ = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        next_flag = 1'b0;
        case (state_q)
            RUN:     if (halt_req)  state_d = STOP;
            STOP:    if (!halt_req) state_d = RUN;
            default: state_d = RUN;
        endcase
        // Gated by reset so the PC is never told to move while held in reset.
        issue     = reset & (state_q == RUN) & ~flush & (occ < DEPTH_C);
        next_flag = issue | (reset & flush);
    end

    assign imem_rd   = issue;
    assign imem_addr = prog_ctr;
    assign halted    = (state_q == STOP) & q_empty & ~inflight_q;

    assign inst_out  = byp ? imem_data : mem_q[rptr_q].inst;
    assign inst_pc   = byp ? tag_q     : mem_q[rptr_q].pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            mem_q      <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            // issue is already suppressed by flush, so this also drops the
            // in-flight response on a redirect.
            inflight_q <= issue;
            if (issue) tag_q <= prog_ctr;
            if (flush) begin
                count_q <= '0;
                rptr_q  <= '0;
                wptr_q  <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= '{pc: tag_q, inst: imem_data};
                    wptr_q        <= wptr_q + AW'(1);
                end
                if (q_pop) rptr_q <= rptr_q + AW'(1);
                count_q <= count_q + CW'(push) - CW'(q_pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int D = 12;
    localparam int W = 9;
    localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [D-1:0] prog_ctr;
    logic         next_flag;
    logic         flush = 1'b0;
    logic         halt_req = 1'b0;
    logic         halted;
    logic         imem_rd;
    logic [D-1:0] imem_addr;
    logic [W-1:0] imem_data = '0;
    logic         inst_valid;
    logic         inst_ready = 1'b0;
    logic [W-1:0] inst_out;
    logic [D-1:0] inst_pc;
    logic [D-1:0] jump_target = '0;

    int total = 0;
    int passed = 0;

    fetch_queue #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .next_flag(next_flag),
        .flush(flush), .halt_req(halt_req), .halted(halted),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    // PC: increments on next_flag, loads the jump target when flushing.
    always @(posedge clk or negedge reset) begin
        if (!reset) prog_ctr <= '0;
        else if (next_flag) prog_ctr <= flush ? jump_target : prog_ctr + 12'd1;
    end

    // ROM: word = low address bits, one cycle read latency.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= imem_addr[W-1:0];
    end

    // Pushing into a full queue must never happen.
    always @(negedge clk) begin
        if (reset && dut.push && dut.count_q == 2'(DEPTH)) begin
            total++;
            $display("FAIL full_push count=%0d push=%0d required no push", dut.count_q, dut.push);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; halt_req = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; inst_ready = 1'b1;
        tick(); tick();
        total++; if (next_flag !== 1'b0) $display("FAIL rst_next_flag got %0d want 0", next_flag); else passed++;
        total++; if (imem_rd !== 1'b0) $display("FAIL rst_imem_rd got %0d want 0", imem_rd); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid got %0d want 0", inst_valid); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL rst_halted got %0d want 0", halted); else passed++;
        total++; if (inst_out !== 9'd0) $display("FAIL rst_inst_out got %0h want 0", inst_out); else passed++;
        total++; if (inst_pc !== 12'd0) $display("FAIL rst_inst_pc got %0h want 0", inst_pc); else passed++;
    endtask

    task automatic test_stream();
        logic [D-1:0] e;
        inst_ready = 1'b1;
        do_reset();
        #1;
        total++; if (imem_rd !== 1'b1 || imem_addr !== 12'd0) $display("FAIL stream_first_issue got rd=%0d addr=%0h want rd=1 addr=0", imem_rd, imem_addr); else passed++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < LAT) begin
                total++; if (inst_valid !== 1'b0) $display("FAIL stream_early_valid cyc %0d got %0d want 0", k, inst_valid); else passed++;
            end else begin
                e = 12'(k - LAT);
                total++; if (inst_valid !== 1'b1 || inst_pc !== e || inst_out !== e[W-1:0])
                    $display("FAIL stream_head cyc %0d got v=%0d pc=%0h out=%0h want v=1 pc=%0h out=%0h", k, inst_valid, inst_pc, inst_out, e, e[W-1:0]);
                else passed++;
            end
            total++; if (next_flag !== 1'b1) $display("FAIL stream_next_flag cyc %0d got %0d want 1", k, next_flag); else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [D-1:0] e;
        inst_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 12'd0) $display("FAIL bp_head got v=%0d pc=%0h want v=1 pc=0", inst_valid, inst_pc); else passed++;
        total++; if (next_flag !== 1'b0 || imem_rd !== 1'b0) $display("FAIL bp_stall got nf=%0d rd=%0d want 0 0", next_flag, imem_rd); else passed++;
        total++; if (prog_ctr !== 12'd2) $display("FAIL bp_pc got %0h want 2", prog_ctr); else passed++;
        inst_ready = 1'b1;
        e = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (inst_valid) begin
                total++; if (inst_pc !== e || inst_out !== e[W-1:0]) $display("FAIL bp_order got pc=%0h out=%0h want %0h", inst_pc, inst_out, e); else passed++;
                e++;
            end
            tick();
        end
        total++; if (e !== 12'd6) $display("FAIL bp_delivered got %0d want 6", e); else passed++;
    endtask

    task automatic test_flush();
        logic [D-1:0] e;
        jump_target = 12'h080;
        inst_ready = 1'b1;
        do_reset();
        repeat (5) tick();
        flush = 1'b1;
        #1;
        total++; if (next_flag !== 1'b1 || imem_rd !== 1'b0) $display("FAIL flush_cycle got nf=%0d rd=%0d want 1 0", next_flag, imem_rd); else passed++;
        tick();
        flush = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0) $display("FAIL flush_after_valid got %0d want 0", inst_valid); else passed++;
        total++; if (imem_rd !== 1'b1 || imem_addr !== 12'h080) $display("FAIL flush_refetch got rd=%0d addr=%0h want 1 80", imem_rd, imem_addr); else passed++;
        e = 12'h080;
        for (int i = 0; i < 6; i++) begin
            if (inst_valid) begin
                total++; if (inst_pc !== e || inst_out !== e[W-1:0]) $display("FAIL flush_order got pc=%0h out=%0h want %0h", inst_pc, inst_out, e); else passed++;
                e++;
            end
            tick();
        end
        total++; if (e !== 12'(12'h080 + 6 - LAT)) $display("FAIL flush_delivered got end %0h want %0h", e, 12'(12'h080 + 6 - LAT)); else passed++;
    endtask

    task automatic test_halt();
        inst_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        halt_req = 1'b1;
        #1;
        total++; if (imem_rd !== 1'b0) $display("FAIL halt_no_issue0 got %0d want 0", imem_rd); else passed++;
        tick();
        inst_ready = 1'b1;
        #1;
        total++; if (halted !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 12'd0) $display("FAIL halt_drain0 got h=%0d v=%0d pc=%0h want 0 1 0", halted, inst_valid, inst_pc); else passed++;
        total++; if (imem_rd !== 1'b0) $display("FAIL halt_no_issue1 got %0d want 0", imem_rd); else passed++;
        tick();
        total++; if (halted !== 1'b0 || inst_pc !== 12'd1 || imem_rd !== 1'b0) $display("FAIL halt_drain1 got h=%0d pc=%0h rd=%0d want 0 1 0", halted, inst_pc, imem_rd); else passed++;
        tick();
        total++; if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_rd !== 1'b0) $display("FAIL halt_done got h=%0d v=%0d rd=%0d want 1 0 0", halted, inst_valid, imem_rd); else passed++;
        halt_req = 1'b0;
        #1;
        total++; if (imem_rd !== 1'b0 || halted !== 1'b1) $display("FAIL halt_release_same got rd=%0d h=%0d want 0 1", imem_rd, halted); else passed++;
        tick();
        total++; if (imem_rd !== 1'b1 || imem_addr !== 12'd2 || halted !== 1'b0) $display("FAIL halt_resume got rd=%0d addr=%0h h=%0d want 1 2 0", imem_rd, imem_addr, halted); else passed++;
        repeat (LAT) tick();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 12'd2) $display("FAIL halt_resume_head got v=%0d pc=%0h want 1 2", inst_valid, inst_pc); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [D-1:0] e;
        inst_ready = 1'b1;
        do_reset();
        repeat (4) tick();
        reset = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0 || inst_pc !== 12'd0 || inst_out !== 9'd0) $display("FAIL mid_rst_outs got v=%0d pc=%0h out=%0h want 0 0 0", inst_valid, inst_pc, inst_out); else passed++;
        total++; if (next_flag !== 1'b0 || imem_rd !== 1'b0) $display("FAIL mid_rst_ctl got nf=%0d rd=%0d want 0 0", next_flag, imem_rd); else passed++;
        #1;
        reset = 1'b1;
        e = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (inst_valid) begin
                total++; if (inst_pc !== e) $display("FAIL mid_rst_order got pc=%0h want %0h", inst_pc, e); else passed++;
                e++;
            end
        end
        total++; if (e !== 12'(7 - LAT)) $display("FAIL mid_rst_delivered got %0d want %0d", e, 7 - LAT); else passed++;
    endtask

    task automatic test_flush_pop_full();
        logic [D-1:0] e;
        jump_target = 12'h040;
        inst_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        flush = 1'b1;
        inst_ready = 1'b1;
        #1;
        total++; if (next_flag !== 1'b1 || inst_valid !== 1'b1 || imem_rd !== 1'b0) $display("FAIL fp_cycle got nf=%0d v=%0d rd=%0d want 1 1 0", next_flag, inst_valid, imem_rd); else passed++;
        tick();
        flush = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0 || dut.count_q !== 2'd0) $display("FAIL fp_cleared got v=%0d count=%0d want 0 0", inst_valid, dut.count_q); else passed++;
        e = 12'h040;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (inst_valid) begin
                total++; if (inst_pc !== e) $display("FAIL fp_order got pc=%0h want %0h", inst_pc, e); else passed++;
                e++;
            end
        end
        total++; if (e !== 12'(12'h040 + 7 - LAT)) $display("FAIL fp_delivered got end %0h want %0h", e, 12'(12'h040 + 7 - LAT)); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_halt();
        test_reset_mid();
        test_flush_pop_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
